// File: rtl/data_mem_ws.sv
// Byte-addressable data memory, valid/ready handshake; response LAT cycles after accept (misaligned word: next cycle).
// Backpressure: one transaction in flight; req_ready low until the response is taken; req_valid outside IDLE is dropped.
module data_mem_ws #(
  parameter int DW  = 16,
  parameter int AW  = 9,
  parameter int LAT = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic [AW:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int CNT_INIT = (LAT > 0) ? LAT - 1 : 0;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_we, r_byte;
  logic [AW:0]   r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [DW-1:0] r_mem [2**AW];

  logic          w_accept, w_req_err, w_access, w_load_err, w_clear;
  logic          w_acc_we, w_acc_byte;
  logic [AW:0]   w_acc_addr;
  logic [DW-1:0] w_acc_wdata;
  logic [AW-1:0] w_idx;
  logic [DW-1:0] w_word, w_wr_word, w_rd_data;
  logic [7:0]    w_lane;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign w_accept   = req_valid & req_ready;
  assign w_req_err  = ~req_byte & req_addr[0];

  // With LAT=0 the array is accessed on the accept edge, so use the live request in IDLE.
  assign w_acc_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_acc_byte  = (r_state == S_IDLE) ? req_byte  : r_byte;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_idx     = w_acc_addr[AW:1];
  assign w_word    = r_mem[w_idx];
  assign w_lane    = w_acc_addr[0] ? w_word[15:8] : w_word[7:0];
  assign w_rd_data = w_acc_byte ? {{(DW-8){w_lane[7]}}, w_lane} : w_word;

  always_comb begin
    w_wr_word = w_acc_wdata;
    if (w_acc_byte) begin
      w_wr_word = w_word;
      if (w_acc_addr[0]) w_wr_word[15:8] = w_acc_wdata[7:0];
      else               w_wr_word[7:0]  = w_acc_wdata[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    w_load_err  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
            w_load_err  = 1'b1;
          end else if (LAT == 0) begin
            w_state_nxt = S_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(CNT_INIT);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Array is not reset; writes are suppressed while reset is held.
  always_ff @(posedge Clk) begin
    if (Rst_n && w_access && w_acc_we) r_mem[w_idx] <= w_wr_word;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_byte  <= req_byte;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_load_err) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end else if (w_access) begin
        r_err   <= 1'b0;
        r_rdata <= w_acc_we ? '0 : w_rd_data;
      end else if (w_clear) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ws.sv
// Bench for data_mem_ws: a LAT=2 instance (index 0) and a LAT=0 instance (index 1) against a word/byte array model.
module tb_data_mem_ws;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic        rv [2];
  logic        wev[2];
  logic        btv[2];
  logic        rr [2];
  logic [9:0]  adv[2];
  logic [15:0] wdv[2];
  wire         rqr[2];
  wire         vld[2];
  wire         erv[2];
  wire  [15:0] rdv[2];

  int          lat_of[2] = '{2, 0};
  logic [15:0] mdl[2][512];

  data_mem_ws #(.DW(16), .AW(9), .LAT(2)) u_dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(rv[0]), .req_ready(rqr[0]), .req_we(wev[0]),
    .req_byte(btv[0]), .req_addr(adv[0]), .req_wdata(wdv[0]), .resp_valid(vld[0]),
    .resp_ready(rr[0]), .resp_rdata(rdv[0]), .resp_err(erv[0]));

  data_mem_ws #(.DW(16), .AW(9), .LAT(0)) u_dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(rv[1]), .req_ready(rqr[1]), .req_we(wev[1]),
    .req_byte(btv[1]), .req_addr(adv[1]), .req_wdata(wdv[1]), .resp_valid(vld[1]),
    .resp_ready(rr[1]), .resp_rdata(rdv[1]), .resp_err(erv[1]));

  // Drives one transaction from a negedge with resp_ready high; returns at the negedge after the handshake.
  task automatic txn(input int w, input logic we, input logic bt, input logic [9:0] a,
                     input logic [15:0] d, output logic [15:0] rd, output logic er,
                     output int lat, output int acc);
    int n;
    rv[w] = 1'b1; wev[w] = we; btv[w] = bt; adv[w] = a; wdv[w] = d; rr[w] = 1'b1;
    n = 0;
    while (rqr[w] !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    @(negedge Clk);
    rv[w] = 1'b0;
    acc = cyc;
    lat = 0;
    while (vld[w] !== 1'b1 && lat < 50) begin @(negedge Clk); lat++; end
    rd = rdv[w];
    er = erv[w];
    @(negedge Clk);
  endtask

  // Reference: memory as an array of 16-bit words, byte lanes by plain arithmetic.
  task automatic mref(input int w, input logic we, input logic bt, input logic [9:0] a,
                      input logic [15:0] d, output logic [15:0] rd, output logic er, output int lat);
    int idx, lane, old, b;
    idx  = int'(a) / 2;
    lane = int'(a) % 2;
    old  = int'(mdl[w][idx]);
    er   = (!bt && lane == 1);
    lat  = er ? 0 : lat_of[w];
    rd   = 16'h0;
    if (er) return;
    if (we) begin
      if (!bt)           mdl[w][idx] = d;
      else if (lane == 1) mdl[w][idx] = 16'((old % 256) + int'(d[7:0]) * 256);
      else               mdl[w][idx] = 16'(old - (old % 256) + int'(d[7:0]));
    end else if (!bt) begin
      rd = 16'(old);
    end else begin
      b  = (lane == 1) ? old / 256 : old % 256;
      rd = (b >= 128) ? 16'(b + 65280) : 16'(b);
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      if (rqr[w] !== 1'b1) begin errors++; $display("FAIL reset_req_ready[%0d]: got %b want 1", w, rqr[w]); end
      checks++;
      if (vld[w] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d]: got %b want 0", w, vld[w]); end
      checks++;
      if (rdv[w] !== 16'h0 || erv[w] !== 1'b0) begin
        errors++; $display("FAIL reset_resp_data[%0d]: got %h/%b want 0000/0", w, rdv[w], erv[w]);
      end
      checks++;
    end
  endtask

  task automatic test_word_rw();
    logic [15:0] rd; logic er; int lat, acc;
    txn(0, 1'b1, 1'b0, 10'h010, 16'hBEEF, rd, er, lat, acc);
    if (lat !== 2 || er !== 1'b0 || rd !== 16'h0) begin
      errors++; $display("FAIL word_write: got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=0000", lat, er, rd);
    end
    checks++;
    if (vld[0] !== 1'b0 || rqr[0] !== 1'b1 || rdv[0] !== 16'h0) begin
      errors++; $display("FAIL idle_after_resp: got vld=%b rdy=%b rdata=%h want 0 1 0000", vld[0], rqr[0], rdv[0]);
    end
    checks++;
    txn(0, 1'b0, 1'b0, 10'h010, 16'h0, rd, er, lat, acc);
    if (rd !== 16'hBEEF || lat !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL word_read: got %h lat=%0d err=%b want beef lat=2 err=0", rd, lat, er);
    end
    checks++;
  endtask

  task automatic test_byte();
    logic [15:0] rd; logic er; int lat, acc;
    txn(0, 1'b1, 1'b1, 10'h011, 16'h0080, rd, er, lat, acc);
    txn(0, 1'b0, 1'b0, 10'h010, 16'h0, rd, er, lat, acc);
    if (rd !== 16'h80EF) begin errors++; $display("FAIL byte_write_merge: got %h want 80ef", rd); end
    checks++;
    txn(0, 1'b0, 1'b1, 10'h011, 16'h0, rd, er, lat, acc);
    if (rd !== 16'hFF80 || er !== 1'b0) begin errors++; $display("FAIL byte_read_hi: got %h want ff80", rd); end
    checks++;
    txn(0, 1'b0, 1'b1, 10'h010, 16'h0, rd, er, lat, acc);
    if (rd !== 16'hFFEF) begin errors++; $display("FAIL byte_read_lo: got %h want ffef", rd); end
    checks++;
  endtask

  task automatic test_error();
    logic [15:0] rd; logic er; int lat, acc;
    txn(1, 1'b1, 1'b0, 10'h012, 16'h4321, rd, er, lat, acc);
    for (int w = 0; w < 2; w++) begin
      txn(w, 1'b0, 1'b0, 10'h013, 16'h0, rd, er, lat, acc);
      if (er !== 1'b1 || rd !== 16'h0 || lat !== 0) begin
        errors++; $display("FAIL misaligned_read[%0d]: got err=%b rdata=%h lat=%0d want 1 0000 0", w, er, rd, lat);
      end
      checks++;
    end
    txn(0, 1'b1, 1'b0, 10'h011, 16'hDEAD, rd, er, lat, acc);
    if (er !== 1'b1 || lat !== 0) begin errors++; $display("FAIL misaligned_write: got err=%b lat=%0d want 1 0", er, lat); end
    checks++;
    txn(0, 1'b0, 1'b0, 10'h010, 16'h0, rd, er, lat, acc);
    if (rd !== 16'h80EF) begin errors++; $display("FAIL err_no_write_lat2: got %h want 80ef", rd); end
    checks++;
    txn(1, 1'b1, 1'b0, 10'h013, 16'hFFFF, rd, er, lat, acc);
    txn(1, 1'b0, 1'b0, 10'h012, 16'h0, rd, er, lat, acc);
    if (rd !== 16'h4321) begin errors++; $display("FAIL err_no_write_lat0: got %h want 4321", rd); end
    checks++;
  endtask

  task automatic test_stall();
    logic [15:0] rd; logic er; int lat, acc, n;
    txn(0, 1'b1, 1'b0, 10'h030, 16'hA5C3, rd, er, lat, acc);
    rv[0] = 1'b1; wev[0] = 1'b0; btv[0] = 1'b0; adv[0] = 10'h030; rr[0] = 1'b0;
    @(negedge Clk);
    rv[0] = 1'b0;
    n = 0;
    while (vld[0] !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    if (n >= 50) begin errors++; $display("FAIL stall_timeout: got no resp_valid within %0d cycles want resp", n); end
    checks++;
    for (int i = 0; i < 5; i++) begin
      if (vld[0] !== 1'b1 || rdv[0] !== 16'hA5C3 || rqr[0] !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: got vld=%b rdata=%h rdy=%b want 1 a5c3 0", i, vld[0], rdv[0], rqr[0]);
      end
      checks++;
      rv[0] = (i == 1 || i == 2); wev[0] = 1'b1; adv[0] = 10'h030; wdv[0] = 16'h0000;
      @(negedge Clk);
    end
    rv[0] = 1'b0;
    rr[0] = 1'b1;
    @(negedge Clk);
    if (vld[0] !== 1'b0 || rqr[0] !== 1'b1) begin
      errors++; $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", vld[0], rqr[0]);
    end
    checks++;
    @(negedge Clk);
    if (vld[0] !== 1'b0 || rqr[0] !== 1'b1) begin
      errors++; $display("FAIL stall_no_queue: got vld=%b rdy=%b want 0 1", vld[0], rqr[0]);
    end
    checks++;
    txn(0, 1'b0, 1'b0, 10'h030, 16'h0, rd, er, lat, acc);
    if (rd !== 16'hA5C3) begin errors++; $display("FAIL stall_pulse_ignored: got %h want a5c3", rd); end
    checks++;
  endtask

  task automatic test_reset_wait();
    logic [15:0] rd; logic er; int lat, acc;
    txn(0, 1'b1, 1'b0, 10'h020, 16'h1234, rd, er, lat, acc);
    rv[0] = 1'b1; wev[0] = 1'b1; btv[0] = 1'b0; adv[0] = 10'h020; wdv[0] = 16'h5678; rr[0] = 1'b1;
    @(negedge Clk);
    rv[0] = 1'b0;
    if (rqr[0] !== 1'b0 || vld[0] !== 1'b0) begin
      errors++; $display("FAIL in_wait: got rdy=%b vld=%b want 0 0", rqr[0], vld[0]);
    end
    checks++;
    #2 Rst_n = 1'b0;
    #1;
    if (rqr[0] !== 1'b1 || vld[0] !== 1'b0 || rdv[0] !== 16'h0 || erv[0] !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rdy=%b vld=%b rdata=%h err=%b want 1 0 0000 0", rqr[0], vld[0], rdv[0], erv[0]);
    end
    checks++;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    txn(0, 1'b0, 1'b0, 10'h020, 16'h0, rd, er, lat, acc);
    if (rd !== 16'h1234) begin errors++; $display("FAIL reset_aborts_write: got %h want 1234", rd); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lat, acc, prev;
    logic [15:0] want;
    txn(1, 1'b1, 1'b0, 10'h040, 16'h1111, rd, er, lat, acc);
    txn(1, 1'b1, 1'b0, 10'h042, 16'h2222, rd, er, lat, acc);
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b0, 1'b0, (i % 2 == 0) ? 10'h040 : 10'h042, 16'h0, rd, er, lat, acc);
      want = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      if (rd !== want || lat !== 0) begin
        errors++; $display("FAIL b2b_read[%0d]: got %h lat=%0d want %h lat=0", i, rd, lat, want);
      end
      checks++;
      if (prev >= 0) begin
        if (acc - prev !== 2) begin errors++; $display("FAIL b2b_spacing_lat0[%0d]: got %0d want 2", i, acc - prev); end
        checks++;
      end
      prev = acc;
    end
    txn(0, 1'b0, 1'b0, 10'h020, 16'h0, rd, er, lat, prev);
    txn(0, 1'b0, 1'b0, 10'h020, 16'h0, rd, er, lat, acc);
    if (acc - prev !== 4) begin errors++; $display("FAIL b2b_spacing_lat2: got %0d want 4", acc - prev); end
    checks++;
  endtask

  task automatic test_random();
    logic [15:0] rd, erd, d; logic er, eer, we, bt; logic [9:0] a; int lat, elat, acc;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        d = 16'($urandom);
        a = 10'(256 + 2 * i);
        mref(w, 1'b1, 1'b0, a, d, erd, eer, elat);
        txn(w, 1'b1, 1'b0, a, d, rd, er, lat, acc);
      end
      for (int i = 0; i < 60; i++) begin
        we = 1'($urandom_range(0, 1));
        bt = 1'($urandom_range(0, 1));
        a  = 10'(256 + $urandom_range(0, 31));
        d  = 16'($urandom);
        mref(w, we, bt, a, d, erd, eer, elat);
        txn(w, we, bt, a, d, rd, er, lat, acc);
        if (rd !== erd || er !== eer || lat !== elat) begin
          errors++;
          $display("FAIL random[%0d.%0d] we=%b byte=%b addr=%h: got rdata=%h err=%b lat=%0d want %h %b %0d",
                   w, i, we, bt, a, rd, er, lat, erd, eer, elat);
        end
        checks++;
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      rv[w] = 1'b0; wev[w] = 1'b0; btv[w] = 1'b0; rr[w] = 1'b1; adv[w] = '0; wdv[w] = '0;
    end
    repeat (2) @(negedge Clk);
    test_reset();
    Rst_n = 1'b1;
    @(negedge Clk);
    test_reset();
    test_word_rw();
    test_byte();
    test_error();
    test_stall();
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
